// File: rtl/uart_tx_store_ctrl.sv
// Store controller: diverts core stores at UART_ADDR into a byte FIFO drained by a
// valid/ready UART port, stalling the PC while the FIFO is full (bounded by STALL_MAX).
module uart_tx_store_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] UART_ADDR = 32'h0000_0100,
  parameter int unsigned STALL_MAX = 1024
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     mem_we,
  input  logic [31:0]              mem_addr,
  input  logic [7:0]               mem_wdata,
  output logic                     dmem_we,
  output logic                     pc_load,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STALL_MAX + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STALL_MAX);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic hit, full, pop, push, drop;

  always_comb begin
    hit      = mem_we && (mem_addr == UART_ADDR);
    dmem_we  = mem_we & ~hit;
    full     = (count_q == FULL_CNT);
    tx_valid = (count_q != '0);
    pop      = tx_valid & tx_ready;
    tx_data  = mem_q[rd_ptr_q];

    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    overflow_d  = overflow_q;
    pc_load     = 1'b1;
    drop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hit && full && !pop) begin
          pc_load     = 1'b0;
          state_d     = S_STALL;
          stall_cnt_d = CW'(1);
        end
      end
      S_STALL: begin
        // Every exit (released, dropped, or store withdrawn) returns to IDLE with PC running.
        state_d     = S_IDLE;
        stall_cnt_d = '0;
        if (hit && full && !pop) begin
          if (stall_cnt_q == CNT_MAX) begin
            drop       = 1'b1;
            overflow_d = 1'b1;
          end else begin
            pc_load     = 1'b0;
            state_d     = S_STALL;
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    push = hit & (~full | pop) & ~drop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // At full with push+pop, wr_ptr == rd_ptr: the old head is read out this cycle
    // and the slot is rewritten as the new tail on the same edge.
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = mem_wdata;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_store_ctrl.sv
// Bench for uart_tx_store_ctrl: a vector table for basic store/fill/drain behaviour plus
// directed sequences for reset, stall release, full push/pop wrap and timeout drop.
module tb_uart_tx_store_ctrl;

  localparam logic [31:0] UA = 32'h0000_0100;

  logic       clk = 1'b0;
  logic       areset;
  logic       mem_we;
  logic [31:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       tx_ready;

  logic       dmem_we, pc_load, tx_valid, overflow;
  logic [7:0] tx_data;
  logic [3:0] fifo_count;

  logic       dmem_we_t, pc_load_t, tx_valid_t, overflow_t;
  logic [7:0] tx_data_t;
  logic [3:0] fifo_count_t;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx_store_ctrl dut (
    .clk(clk), .areset(areset), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .dmem_we(dmem_we), .pc_load(pc_load),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  uart_tx_store_ctrl #(.STALL_MAX(4)) dut_to (
    .clk(clk), .areset(areset), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .dmem_we(dmem_we_t), .pc_load(pc_load_t),
    .tx_data(tx_data_t), .tx_valid(tx_valid_t), .tx_ready(tx_ready),
    .fifo_count(fifo_count_t), .overflow(overflow_t)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        rdy;
    logic        e_dmem;
    logic        e_pc;
    logic        e_valid;
    logic [7:0]  e_data;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add_vec(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                         input logic rdy, input logic e_dmem, input logic e_pc,
                         input logic e_valid, input logic [7:0] e_data, input logic [3:0] e_cnt);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd; v.rdy = rdy;
    v.e_dmem = e_dmem; v.e_pc = e_pc; v.e_valid = e_valid; v.e_data = e_data; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later,
  // well before the next rising edge.
  task automatic drive(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                       input logic rdy);
    @(negedge clk);
    mem_we = we; mem_addr = addr; mem_wdata = wd; tx_ready = rdy;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; tx_ready = 1'b0;
    areset = 1'b0;
    #2;
    areset = 1'b1;
  endtask

  initial begin
    areset = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    areset = 1'b1;

    // ---- table: single store, non-UART store, fill 8, drain in order ----
    add_vec(0, 32'h0,   8'h00, 0, 0, 1, 0, 8'h00, 4'd0);
    add_vec(1, UA,      8'h41, 0, 0, 1, 0, 8'h00, 4'd0);
    add_vec(0, 32'h0,   8'h00, 0, 0, 1, 1, 8'h41, 4'd1);
    add_vec(1, 32'h104, 8'h99, 0, 1, 1, 1, 8'h41, 4'd1);
    add_vec(0, 32'h0,   8'h00, 0, 0, 1, 1, 8'h41, 4'd1);
    add_vec(0, 32'h0,   8'h00, 1, 0, 1, 1, 8'h41, 4'd1);
    add_vec(0, 32'h0,   8'h00, 0, 0, 1, 0, 8'h00, 4'd0);
    for (int i = 0; i < 8; i++)
      add_vec(1, UA, 8'(i), 0, 0, 1, (i > 0), 8'h00, 4'(i));
    for (int j = 0; j < 8; j++)
      add_vec(0, 32'h0, 8'h00, 1, 0, 1, 1, 8'(j), 4'(8 - j));
    add_vec(0, 32'h0, 8'h00, 0, 0, 1, 0, 8'h00, 4'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
      check($sformatf("v%0d_dmem_we", i), 32'(dmem_we), 32'(vecs[i].e_dmem));
      check($sformatf("v%0d_pc_load", i), 32'(pc_load), 32'(vecs[i].e_pc));
      check($sformatf("v%0d_tx_valid", i), 32'(tx_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      if (vecs[i].e_valid) check($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].e_data));
    end

    // ---- asynchronous reset with queued bytes and a store pending ----
    for (int i = 0; i < 3; i++) drive(1, UA, 8'hC0 + 8'(i), 0);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = UA; mem_wdata = 8'hEE; tx_ready = 1'b0;
    #1;
    check("rst_pre_count", 32'(fifo_count), 32'd3);
    areset = 1'b0;
    #1;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_pc_load", 32'(pc_load), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dmem_we_uart", 32'(dmem_we), 32'd0);
    mem_addr = 32'h104;
    #1;
    check("rst_dmem_we_other", 32'(dmem_we), 32'd1);
    @(negedge clk);
    mem_we = 1'b0; mem_addr = '0;
    areset = 1'b1;

    // ---- full stall released by tx_ready after 5 stall cycles ----
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, UA, 8'h10 + 8'(i), 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, UA, 8'h55, 0);
      check($sformatf("stall%0d_pc_load", k), 32'(pc_load), 32'd0);
    end
    drive(1, UA, 8'h55, 1);
    check("release_pc_load", 32'(pc_load), 32'd1);
    check("release_head", 32'(tx_data), 32'h10);
    drive(0, 32'h0, 8'h00, 0);
    check("release_count", 32'(fifo_count), 32'd8);
    check("release_pc_after", 32'(pc_load), 32'd1);
    for (int k = 0; k < 8; k++) begin
      drive(0, 32'h0, 8'h00, 1);
      check($sformatf("rel_drain%0d", k), 32'(tx_data), (k < 7) ? 32'h11 + 32'(k) : 32'h55);
    end
    drive(0, 32'h0, 8'h00, 0);
    check("rel_empty_valid", 32'(tx_valid), 32'd0);
    check("rel_empty_count", 32'(fifo_count), 32'd0);

    // ---- push+pop at full across the pointer wrap ----
    for (int i = 0; i < 8; i++) drive(1, UA, 8'h20 + 8'(i), 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, UA, 8'h60 + 8'(i), 1);
      check($sformatf("pp%0d_pc_load", i), 32'(pc_load), 32'd1);
      check($sformatf("pp%0d_count", i), 32'(fifo_count), 32'd8);
      check($sformatf("pp%0d_head", i), 32'(tx_data), 32'h20 + 32'(i));
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 32'h0, 8'h00, 1);
      check($sformatf("pp_drain%0d", i), 32'(tx_data), 32'h60 + 32'(i));
    end
    drive(0, 32'h0, 8'h00, 0);
    check("pp_empty_count", 32'(fifo_count), 32'd0);

    // ---- timeout drop on the STALL_MAX=4 instance ----
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, UA, 8'h30 + 8'(i), 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, UA, 8'hAA, 0);
      check($sformatf("to%0d_pc_load", k), 32'(pc_load_t), (k < 4) ? 32'd0 : 32'd1);
      check($sformatf("to%0d_overflow", k), 32'(overflow_t), 32'd0);
    end
    drive(0, 32'h0, 8'h00, 0);
    check("to_overflow_set", 32'(overflow_t), 32'd1);
    check("to_count", 32'(fifo_count_t), 32'd8);
    check("to_pc_load_after", 32'(pc_load_t), 32'd1);
    check("long_stall_no_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 32'h0, 8'h00, 1);
      check($sformatf("to_drain%0d", i), 32'(tx_data_t), 32'h30 + 32'(i));
    end
    drive(0, 32'h0, 8'h00, 0);
    check("to_empty_valid", 32'(tx_valid_t), 32'd0);
    check("to_overflow_sticky", 32'(overflow_t), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
